// File: rtl/sqrt_unit_if.sv
// sqrt_unit_if
//   Handshake bundle for the square-root unit.
//   in_valid  : single-cycle strobe qualifying in_data (from the divider's out_valid)
//   in_data   : radicand, Q10.10 unsigned (20 bits)
//   in_ready  : high while the unit can accept a new radicand
//   out_valid : one-cycle pulse qualifying out_data
//   out_data  : root, Q5.10 unsigned (15 bits), truncated
//
// Handshake: a radicand is transferred on a rising edge where in_valid and
// in_ready are both high; in_valid while in_ready is low is ignored and has
// no effect. out_valid is a pulse with no back-pressure; the consumer must
// take out_data in that cycle (out_data also holds until the next result).
//
// Modports: master = producer/consumer side (bench or divider glue),
//           slave  = the square-root unit.
interface sqrt_unit_if;
  logic        in_valid;
  logic [19:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [14:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/sqrt_unit.sv
// sqrt_unit
//   Bit-serial restoring square root. Computes the largest R (Q5.10) such
//   that R*R <= in_data * 2^10, deciding one root bit per cycle, MSB first.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   rst_n     : synchronous, active-low reset
//   bus       : sqrt_unit_if.slave (in_valid/in_data/in_ready/out_valid/out_data)
//   dbg_state : current FSM state (0 = IDLE, 1 = CALC, 2 = DONE)
//
// Configuration macro
//   SQRT_EARLY_EXIT_EN : when defined, a CALC cycle whose trial square equals
//                        the radicand exactly finishes immediately. The root
//                        value is the same either way; only latency changes.
//                        When undefined, all 15 CALC cycles always run
//                        (in_valid cycle 0, out_valid cycle 16).
module sqrt_unit (
  input  logic        clk,
  input  logic        rst_n,
  sqrt_unit_if.slave  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Radicand scaled by 2^10 so that a Q5.10 root squared (Q10.20) compares
  // directly against it as plain 30-bit integers.
  logic [29:0] radicand_q;
  logic [14:0] root_q;
  logic [3:0]  idx_q;
  logic [14:0] out_data_q;

  // Per-cycle trial values
  logic [14:0] guess;
  logic [29:0] guess_sq;
  logic        take;
  logic        exact;
  logic        last_bit;
  logic        finish;
  logic [14:0] root_next;

  // ---------------------------------------------------------------------------
  // Trial bit evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    guess     = root_q | (15'd1 << idx_q);
    // Both operands zero-extended to 30 bits: a 15x15 product never overflows.
    guess_sq  = {15'd0, guess} * {15'd0, guess};
    take      = (guess_sq <= radicand_q);
    root_next = take ? guess : root_q;
    last_bit  = (idx_q == 4'd0);
`ifdef SQRT_EARLY_EXIT_EN
    // An exact square means every lower bit would be rejected anyway, so the
    // current root_next is already the final answer.
    exact     = (guess_sq == radicand_q);
`else
    exact     = 1'b0;
`endif
    finish    = last_bit || exact;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (finish) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      radicand_q <= 30'd0;
      root_q     <= 15'd0;
      idx_q      <= 4'd14;
      out_data_q <= 15'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            radicand_q <= {bus.in_data, 10'd0};
            root_q     <= 15'd0;
            idx_q      <= 4'd14;
          end
        end
        CALC: begin
          root_q <= root_next;
          if (finish) begin
            // Result register only moves on the way into DONE.
            out_data_q <= root_next;
          end else begin
            idx_q <= idx_q - 4'd1;
          end
        end
        default: begin
          // DONE: hold everything; IDLE reloads on the next accept.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore: decoded from state only)
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sqrt_unit.sv
// tb_sqrt_unit
//   Directed-vector bench for sqrt_unit. The driver pushes the hand-computed
//   root and the cycle in which out_valid is due onto queues; a separate
//   monitor pops and compares on every out_valid pulse.
module tb_sqrt_unit;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  sqrt_unit_if bus ();

  sqrt_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset / cycle counter
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Expected latencies (in_valid cycle -> out_valid cycle)
  // ---------------------------------------------------------------------------
`ifdef SQRT_EARLY_EXIT_EN
  localparam int L_4P0   = 5;   // 2.0 = bit 11 only, exact at idx 11
  localparam int L_0P25  = 7;   // 0.5 = bit 9, exact at idx 9
  localparam int L_1P0   = 6;   // 1.0 = bit 10, exact at idx 10
  localparam int L_36P0  = 5;   // 6.0 = bits 12,11, exact at idx 11
  localparam int L_9P0   = 6;   // 3.0 = bits 11,10, exact at idx 10
  localparam int L_TINY  = 11;  // 1/32 = bit 5, exact at idx 5
`else
  localparam int L_4P0   = 16;
  localparam int L_0P25  = 16;
  localparam int L_1P0   = 16;
  localparam int L_36P0  = 16;
  localparam int L_9P0   = 16;
  localparam int L_TINY  = 16;
`endif
  localparam int L_FULL  = 16;

  // ---------------------------------------------------------------------------
  // Scoreboard state and check helper
  // ---------------------------------------------------------------------------
  logic [14:0] exp_q[$];
  int          due_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          pulses = 0;
  bit          ready_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && ready_pending) begin
      check("ready_after_done", 32'(bus.in_ready), 32'd1);
      ready_pending = 1'b0;
    end
    if (rst_n && bus.out_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(bus.out_data), 32'hFFFF_FFFF);
      end else begin
        logic [14:0] e;
        int          d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e));
        check("out_valid_cycle", 32'(cyc), 32'(d));
        ready_pending = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called and returning at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [19:0] d, input logic [14:0] exp, input int lat, input bit track);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (track) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + lat);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 20'h0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      due_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [19:0] din;
    logic [14:0] root;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int p0;
    int n;

    vecs[0] = '{20'h01000, 15'h0800, L_4P0};   // 4.0    -> 2.0
    vecs[1] = '{20'h00800, 15'h05A8, L_FULL};  // 2.0    -> 1.41406
    vecs[2] = '{20'h00000, 15'h0000, L_FULL};  // 0      -> 0
    vecs[3] = '{20'hFFFFF, 15'h7FFF, L_FULL};  // max    -> max
    vecs[4] = '{20'h00100, 15'h0200, L_0P25};  // 0.25   -> 0.5
    vecs[5] = '{20'h00400, 15'h0400, L_1P0};   // 1.0    -> 1.0
    vecs[6] = '{20'h02400, 15'h0C00, L_9P0};   // 9.0    -> 3.0
    vecs[7] = '{20'h00001, 15'h0020, L_TINY};  // 2^-10  -> 2^-5
    vecs[8] = '{20'h00003, 15'h0037, L_FULL};  // 3*2^-10 -> 55*2^-10
    vecs[9] = '{20'h19000, 15'h2800, L_36P0};  // 100.0  -> 10.0

    bus.in_valid = 1'b0;
    bus.in_data  = 20'h0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);

    // One vector at a time, each drained before the next
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].din, vecs[i].root, vecs[i].lat, 1'b1);
      wait_drain();
      check("out_data_hold", 32'(bus.out_data), 32'(vecs[i].root));
    end

    // Back-to-back: next send waits for in_ready, so accept is at cycle 17
    send(20'h01000, 15'h0800, L_4P0, 1'b1);
    send(20'h00800, 15'h05A8, L_FULL, 1'b1);
    wait_drain();

    // in_valid during CALC is ignored
    p0 = pulses;
    send(20'h01000, 15'h0800, L_4P0, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 20'h00400;
    check("ready_low_at_pulse", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 20'h0;
    n = 0;
    do begin
      check("ready_low_busy", 32'(bus.in_ready), 32'd0);
      if (!bus.out_valid) @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 40);
    check("ready_low_in_done", 32'(bus.in_ready), 32'd0);
    wait_drain();
    repeat (20) @(negedge clk);
    check("single_pulse", 32'(pulses - p0), 32'd1);

    // Reset during cycle 8 of an operation aborts it
    p0 = pulses;
    send(20'h00800, 15'h05A8, L_FULL, 1'b0);   // now in cycle 1
    repeat (7) @(negedge clk);                  // cycle 8
    rst_n = 1'b0;
    @(negedge clk);                             // cycle 9
    rst_n = 1'b1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_data", 32'(bus.out_data), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_pulse", 32'(pulses - p0), 32'd0);

    send(20'h09000, 15'h1800, L_36P0, 1'b1);    // 36.0 -> 6.0
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
